// File: rtl/alu_share_arb_pkg.sv
// alu_share_arb_pkg: shared FSM state encoding and default widths for the ALU share arbiter.
package alu_share_arb_pkg;
    localparam int DW_DEF = 8;
    localparam int FW = 3;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;
endpackage

// File: rtl/alu_share_arb_if.sv
// alu_share_arb_if: one requester's operation (req) and result (rsp) valid/ready channels.
//   req_valid/req_ready/req_f/req_a/req_b : operation offer towards the arbiter
//   rsp_valid/rsp_ready/rsp_r/rsp_ovf     : captured ALU result back to the requester
//   master = requester side, slave = arbiter side
interface alu_share_arb_if
    import alu_share_arb_pkg::*;
#(
    parameter int DW = DW_DEF
);
    logic          req_valid;
    logic          req_ready;
    logic [FW-1:0] req_f;
    logic [DW-1:0] req_a;
    logic [DW-1:0] req_b;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_r;
    logic          rsp_ovf;
    modport master (
        output req_valid, req_f, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_r, rsp_ovf
    );
    modport slave (
        input  req_valid, req_f, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_r, rsp_ovf
    );
endinterface

// File: rtl/alu_share_arb_rr_arb2.sv
// rr_arb2: two-way arbiter producing a one-hot grant from the request valids.
//   i_valid      : {req1_valid, req0_valid}
//   i_last_grant : index of the previous winner
//   i_rr_en      : 1 = round-robin on contention, 0 = req0 always wins
//   o_grant      : one-hot grant, zero when nobody is requesting
module rr_arb2 (
    input  logic [1:0] i_valid,
    input  logic       i_last_grant,
    input  logic       i_rr_en,
    output logic [1:0] o_grant
);
    // Only contention needs a decision; a lone requester is its own grant.
    assign o_grant = (i_valid == 2'b11) ? ((i_rr_en && !i_last_grant) ? 2'b10 : 2'b01) : i_valid;
endmodule

// File: rtl/alu_share_arb.sv
// alu_share_arb: sequences two requesters onto one shared combinational ALU and returns results.
//   clk, rst_n        : clock, asynchronous active-low reset
//   port0, port1      : requester channels (slave side of alu_share_arb_if)
//   o_alu_f/a/b       : operation to the external ALU, always from the op registers
//   i_alu_r, i_alu_ovf: ALU result and overflow, captured at the end of EXEC
//   o_busy            : FSM not idle
//   o_ovf_count       : saturating count of completed ops that overflowed
//   i_clr_ovf_count   : synchronous clear of o_ovf_count, wins over an increment
module alu_share_arb
    import alu_share_arb_pkg::*;
#(
    parameter int DW        = DW_DEF,
    parameter int OVF_CNT_W = 8,
    parameter bit RR_EN     = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_share_arb_if.slave       port0,
    alu_share_arb_if.slave       port1,
    output logic [FW-1:0]        o_alu_f,
    output logic [DW-1:0]        o_alu_a,
    output logic [DW-1:0]        o_alu_b,
    input  logic [DW-1:0]        i_alu_r,
    input  logic                 i_alu_ovf,
    output logic                 o_busy,
    output logic [OVF_CNT_W-1:0] o_ovf_count,
    input  logic                 i_clr_ovf_count
);
    state_t                r_state;
    state_t                w_next;
    logic                  r_owner;
    logic                  r_last;
    logic [FW-1:0]         r_f;
    logic [DW-1:0]         r_a;
    logic [DW-1:0]         r_b;
    logic [DW-1:0]         r_rsp0_r;
    logic [DW-1:0]         r_rsp1_r;
    logic                  r_rsp0_ovf;
    logic                  r_rsp1_ovf;
    logic [OVF_CNT_W-1:0]  r_cnt;
    logic [1:0]            w_grant;
    logic                  w_hs;
    logic                  w_rsp_rdy;
    rr_arb2 u_arb (
        .i_valid      ({port1.req_valid, port0.req_valid}),
        .i_last_grant (r_last),
        .i_rr_en      (RR_EN),
        .o_grant      (w_grant)
    );
    // A grant is only issued in IDLE and doubles as ready, so grant == handshake.
    assign w_hs      = (r_state == IDLE) && (|w_grant);
    assign w_rsp_rdy = r_owner ? port1.rsp_ready : port0.rsp_ready;
    assign o_busy    = (r_state != IDLE);
    assign o_alu_f   = r_f;
    assign o_alu_a   = r_a;
    assign o_alu_b   = r_b;
    assign o_ovf_count   = r_cnt;
    assign port0.rsp_r   = r_rsp0_r;
    assign port0.rsp_ovf = r_rsp0_ovf;
    assign port1.rsp_r   = r_rsp1_r;
    assign port1.rsp_ovf = r_rsp1_ovf;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end
    always_comb begin
        w_next          = r_state;
        port0.req_ready = 1'b0;
        port1.req_ready = 1'b0;
        port0.rsp_valid = 1'b0;
        port1.rsp_valid = 1'b0;
        case (r_state)
            IDLE: begin
                port0.req_ready = w_grant[0];
                port1.req_ready = w_grant[1];
                w_next          = (|w_grant) ? EXEC : IDLE;
            end
            EXEC: w_next = RESP;
            RESP: begin
                port0.rsp_valid = !r_owner;
                port1.rsp_valid = r_owner;
                w_next          = w_rsp_rdy ? IDLE : RESP;
            end
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner    <= 1'b0;
            r_last     <= 1'b1;
            r_f        <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_rsp0_r   <= '0;
            r_rsp1_r   <= '0;
            r_rsp0_ovf <= 1'b0;
            r_rsp1_ovf <= 1'b0;
        end else begin
            if (w_hs) begin
                r_owner <= w_grant[1];
                r_last  <= w_grant[1];
                r_f     <= w_grant[1] ? port1.req_f : port0.req_f;
                r_a     <= w_grant[1] ? port1.req_a : port0.req_a;
                r_b     <= w_grant[1] ? port1.req_b : port0.req_b;
            end
            if (r_state == EXEC && r_owner) begin
                r_rsp1_r   <= i_alu_r;
                r_rsp1_ovf <= i_alu_ovf;
            end
            if (r_state == EXEC && !r_owner) begin
                r_rsp0_r   <= i_alu_r;
                r_rsp0_ovf <= i_alu_ovf;
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                         r_cnt <= '0;
        else if (i_clr_ovf_count)                           r_cnt <= '0;
        else if (r_state == EXEC && i_alu_ovf && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
    end
endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: self-checking bench with a stub adder ALU, round-robin and fixed-priority DUTs.
module tb_alu_share_arb;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic [2:0] af, pf;
    logic [7:0] aa, ab, ar, pa, pb, pr, cnt, pcnt;
    logic       aovf, povf, busy, pbusy;
    int         n_tests = 0;
    int         n_fail = 0;
    int         m_last = 1;
    int         m_cnt = 0;
    always #5 clk = ~clk;
    alu_share_arb_if q0 ();
    alu_share_arb_if q1 ();
    alu_share_arb_if p0 ();
    alu_share_arb_if p1 ();
    assign ar   = aa + ab;
    assign aovf = (aa[7] == ab[7]) && (ar[7] != aa[7]);
    assign pr   = pa + pb;
    assign povf = (pa[7] == pb[7]) && (pr[7] != pa[7]);
    assign p0.req_valid = q0.req_valid;
    assign p0.req_f     = q0.req_f;
    assign p0.req_a     = q0.req_a;
    assign p0.req_b     = q0.req_b;
    assign p0.rsp_ready = q0.rsp_ready;
    assign p1.req_valid = q1.req_valid;
    assign p1.req_f     = q1.req_f;
    assign p1.req_a     = q1.req_a;
    assign p1.req_b     = q1.req_b;
    assign p1.rsp_ready = q1.rsp_ready;
    alu_share_arb #(.RR_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .port0(q0), .port1(q1),
        .o_alu_f(af), .o_alu_a(aa), .o_alu_b(ab), .i_alu_r(ar), .i_alu_ovf(aovf),
        .o_busy(busy), .o_ovf_count(cnt), .i_clr_ovf_count(clr)
    );
    alu_share_arb #(.RR_EN(1'b0)) dut_fp (
        .clk(clk), .rst_n(rst_n), .port0(p0), .port1(p1),
        .o_alu_f(pf), .o_alu_a(pa), .o_alu_b(pb), .i_alu_r(pr), .i_alu_ovf(povf),
        .o_busy(pbusy), .o_ovf_count(pcnt), .i_clr_ovf_count(clr)
    );
    typedef struct {
        bit         v0, v1;
        logic [7:0] a0, b0, a1, b1;
        int         dly, ew;
        logic [7:0] er;
        bit         eo;
    } vec_t;
    vec_t tbl[8];
    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    function automatic void model(input logic [7:0] a, b, output logic [7:0] r, output bit ovf);
        int s;
        s   = int'($signed(a)) + int'($signed(b));
        r   = 8'(a + b);
        ovf = (s > 127) || (s < -128);
    endfunction
    task automatic run_op(input bit v0, v1, input logic [7:0] a0, b0, a1, b1,
                          input int dly, ew, input logic [7:0] er, input bit eo);
        logic [7:0] wa;
        wa = (ew != 0) ? a1 : a0;
        if (eo && m_cnt < 255) m_cnt++;
        m_last = ew;
        q0.req_valid = v0; q1.req_valid = v1;
        q0.req_f = 3'd1; q1.req_f = 3'd6;
        q0.req_a = a0; q0.req_b = b0; q1.req_a = a1; q1.req_b = b1;
        q0.rsp_ready = 1'b0; q1.rsp_ready = 1'b0;
        #2;
        chk("idle_busy", int'(busy), 0);
        chk("grant_ready0", int'(q0.req_ready), int'(ew == 0));
        chk("grant_ready1", int'(q1.req_ready), int'(ew == 1));
        tick();
        q0.req_valid = 1'b0; q1.req_valid = 1'b0;
        q0.req_a = 8'hEE; q1.req_a = 8'hEE;
        #2;
        chk("exec_busy", int'(busy), 1);
        chk("exec_rsp_valid", int'(q0.rsp_valid | q1.rsp_valid), 0);
        chk("exec_alu_a", int'(aa), int'(wa));
        chk("exec_alu_f", int'(af), (ew != 0) ? 6 : 1);
        tick();
        #2;
        for (int k = 0; k <= dly; k++) begin
            chk("rsp_valid_own", int'((ew != 0) ? q1.rsp_valid : q0.rsp_valid), 1);
            chk("rsp_valid_other", int'((ew != 0) ? q0.rsp_valid : q1.rsp_valid), 0);
            chk("rsp_r", int'((ew != 0) ? q1.rsp_r : q0.rsp_r), int'(er));
            chk("rsp_ovf", int'((ew != 0) ? q1.rsp_ovf : q0.rsp_ovf), int'(eo));
            chk("ovf_count", int'(cnt), m_cnt);
            chk("resp_busy", int'(busy), 1);
            chk("resp_req_ready", int'(q0.req_ready | q1.req_ready), 0);
            chk("resp_alu_a_held", int'(aa), int'(wa));
            if (k == dly) begin
                q0.req_valid = 1'b0; q1.req_valid = 1'b0;
                if (ew != 0) q1.rsp_ready = 1'b1;
                else         q0.rsp_ready = 1'b1;
                tick();
            end else begin
                q0.req_valid = 1'b1; q1.req_valid = 1'b1;
                tick();
                #2;
            end
        end
        q0.rsp_ready = 1'b0; q1.rsp_ready = 1'b0;
        #2;
        chk("done_busy", int'(busy), 0);
        chk("done_rsp_valid", int'(q0.rsp_valid | q1.rsp_valid), 0);
    endtask
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        logic [7:0] er, ra0, rb0, ra1, rb1;
        bit         eo;
        int         sel, ew;
        q0.req_valid = 1'b0; q1.req_valid = 1'b0;
        q0.req_f = 3'd0; q1.req_f = 3'd0;
        q0.req_a = 8'h00; q0.req_b = 8'h00; q1.req_a = 8'h00; q1.req_b = 8'h00;
        q0.rsp_ready = 1'b0; q1.rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_busy", int'(busy), 0);
        chk("rst_rsp_valid", int'(q0.rsp_valid | q1.rsp_valid), 0);
        chk("rst_req_ready", int'(q0.req_ready | q1.req_ready), 0);
        chk("rst_rsp0_r", int'(q0.rsp_r), 0);
        chk("rst_rsp1_ovf", int'(q1.rsp_ovf), 0);
        chk("rst_alu_a", int'(aa), 0);
        chk("rst_alu_f", int'(af), 0);
        chk("rst_ovf_count", int'(cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tbl[0] = '{1'b1, 1'b0, 8'h05, 8'h03, 8'h00, 8'h00, 0, 0, 8'h08, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 8'h7F, 8'h01, 8'h00, 8'h00, 0, 0, 8'h80, 1'b1};
        tbl[2] = '{1'b1, 1'b1, 8'h11, 8'h22, 8'h80, 8'h80, 1, 1, 8'h00, 1'b1};
        tbl[3] = '{1'b1, 1'b1, 8'hC0, 8'hC0, 8'h33, 8'h44, 2, 0, 8'h80, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 8'h00, 8'h00, 8'h40, 8'h40, 5, 1, 8'h80, 1'b1};
        tbl[5] = '{1'b0, 1'b1, 8'h00, 8'h00, 8'hFF, 8'h01, 0, 1, 8'h00, 1'b0};
        tbl[6] = '{1'b1, 1'b1, 8'h01, 8'h02, 8'h55, 8'h66, 1, 0, 8'h03, 1'b0};
        tbl[7] = '{1'b1, 1'b1, 8'h10, 8'h10, 8'h7F, 8'h7F, 0, 1, 8'hFE, 1'b1};
        for (int i = 0; i < 8; i++)
            run_op(tbl[i].v0, tbl[i].v1, tbl[i].a0, tbl[i].b0, tbl[i].a1, tbl[i].b1,
                   tbl[i].dly, tbl[i].ew, tbl[i].er, tbl[i].eo);
        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(1, 3);
            ra0 = 8'($urandom); rb0 = 8'($urandom); ra1 = 8'($urandom); rb1 = 8'($urandom);
            ew  = (sel == 3) ? ((m_last == 0) ? 1 : 0) : ((sel == 2) ? 1 : 0);
            model((ew != 0) ? ra1 : ra0, (ew != 0) ? rb1 : rb0, er, eo);
            run_op(sel[0], sel[1], ra0, rb0, ra1, rb1, $urandom_range(0, 3), ew, er, eo);
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        #2;
        chk("clr_count", int'(cnt), 0);
        q0.req_valid = 1'b1; q0.req_a = 8'h7F; q0.req_b = 8'h01;
        q0.rsp_ready = 1'b1; q1.rsp_ready = 1'b1;
        repeat (800) tick();
        q0.req_valid = 1'b0;
        for (int k = 0; k < 10 && busy; k++) tick();
        chk("sat_drain_busy", int'(busy), 0);
        chk("sat_count", int'(cnt), 255);
        q0.req_valid = 1'b1;
        tick();
        q0.req_valid = 1'b0;
        clr = 1'b1;
        #2;
        chk("clr_exec_busy", int'(busy), 1);
        tick();
        clr = 1'b0;
        #2;
        chk("clr_wins", int'(cnt), 0);
        chk("clr_rsp_valid", int'(q0.rsp_valid), 1);
        tick();
        q0.rsp_ready = 1'b0; q1.rsp_ready = 1'b0;
        q0.req_valid = 1'b1; q0.req_a = 8'h7F; q0.req_b = 8'h01;
        tick();
        q0.req_valid = 1'b0;
        chk("rst_exec_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_alu_a", int'(aa), 0);
        chk("rst_mid_rsp0_r", int'(q0.rsp_r), 0);
        chk("rst_mid_rsp_valid", int'(q0.rsp_valid | q1.rsp_valid), 0);
        chk("rst_mid_count", int'(cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            #2;
            chk("post_rst_rsp_valid", int'(q0.rsp_valid | q1.rsp_valid), 0);
            chk("post_rst_busy", int'(busy), 0);
        end
        tick();
        q0.req_valid = 1'b1; q1.req_valid = 1'b1;
        q0.rsp_ready = 1'b1; q1.rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #2;
            chk("rr_ready0", int'(q0.req_ready), int'(k % 2 == 0));
            chk("rr_ready1", int'(q1.req_ready), int'(k % 2 == 1));
            chk("fp_ready0", int'(p0.req_ready), 1);
            chk("fp_ready1", int'(p1.req_ready), 0);
            repeat (3) tick();
        end
        q0.req_valid = 1'b0; q1.req_valid = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
